// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single-port data RAM between the CPU data port and the DMA port.
// Define DRAM_ARB_RR_EN for strict round-robin; otherwise the CPU has priority, bounded by STARVE_MAX.
module dram_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              d_ram_rena,
    output logic              d_ram_wena,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;      // 1 = DMA owns the current access
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        lat_q, lat_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              grant_dma;
    logic              issue;

    assign issue = (state_q == IDLE) & (cpu_req | dma_req);

`ifdef DRAM_ARB_RR_EN
    logic last_owner_q;

    // On a tie the master that did not own the previous access wins.
    assign grant_dma = dma_req & (~cpu_req | ~last_owner_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_q <= 1'b1;
        end else if (issue) begin
            last_owner_q <= grant_dma;
        end
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_q, starve_d;

    assign grant_dma = dma_req & (~cpu_req | (starve_q == STARVE_LIM));

    always_comb begin
        starve_d = starve_q;
        if (issue) begin
            if (grant_dma || !dma_req) begin
                starve_d = '0;
            end else if (starve_q != STARVE_LIM) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lat_d       = lat_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    owner_d = grant_dma;
                    we_d    = grant_dma ? dma_we    : cpu_we;
                    addr_d  = grant_dma ? dma_addr  : cpu_addr;
                    wdata_d = grant_dma ? dma_wdata : cpu_wdata;
                    lat_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                lat_d = lat_q + 3'd1;
                if (lat_q == LAT_LAST) begin
                    if (!we_q) begin
                        if (owner_q) dma_rdata_d = ram_rdata;
                        else         cpu_rdata_d = ram_rdata;
                    end
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lat_q       <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lat_q       <= lat_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Enables and acks decode from the registered state, so an async reset drops them at once.
    assign d_ram_rena = (state_q == ACCESS) & ~we_q;
    assign d_ram_wena = (state_q == ACCESS) &  we_q;
    assign ram_addr   = addr_q;
    assign ram_wdata  = wdata_q;
    assign cpu_ack    = (state_q == RESP) & ~owner_q;
    assign dma_ack    = (state_q == RESP) &  owner_q;
    assign cpu_stall  = cpu_req & ~cpu_ack;
    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: one instance with MEM_LAT=3, one with MEM_LAT=1.
module tb_dram_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dma_req, dma_we, dma_ack;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          rena, wena;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    logic          cpu_req1, cpu_we1, cpu_ack1, cpu_stall1;
    logic [AW-1:0] cpu_addr1;
    logic [DW-1:0] cpu_wdata1, cpu_rdata1;
    logic          dma_req1, dma_we1, dma_ack1;
    logic [AW-1:0] dma_addr1;
    logic [DW-1:0] dma_wdata1, dma_rdata1;
    logic          rena1, wena1;
    logic [AW-1:0] ram_addr1;
    logic [DW-1:0] ram_wdata1, ram_rdata1;

    int n_cmp = 0;
    int n_err = 0;

    dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .d_ram_rena(rena), .d_ram_wena(wena), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req1), .cpu_we(cpu_we1), .cpu_addr(cpu_addr1), .cpu_wdata(cpu_wdata1),
        .cpu_rdata(cpu_rdata1), .cpu_ack(cpu_ack1), .cpu_stall(cpu_stall1),
        .dma_req(dma_req1), .dma_we(dma_we1), .dma_addr(dma_addr1), .dma_wdata(dma_wdata1),
        .dma_rdata(dma_rdata1), .dma_ack(dma_ack1),
        .d_ram_rena(rena1), .d_ram_wena(wena1), .ram_addr(ram_addr1),
        .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int  nack;
    int  nbad;
    logic got_dma [0:9];
    logic exp_dma;

    initial begin
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        ram_rdata = '0;
        cpu_req1 = 1'b0; cpu_we1 = 1'b0; cpu_addr1 = '0; cpu_wdata1 = '0;
        dma_req1 = 1'b0; dma_we1 = 1'b0; dma_addr1 = '0; dma_wdata1 = '0;
        ram_rdata1 = '0;

        // Reset held with a pending CPU request
        step(); step();
        check_val("rst_rena", rena, 0);
        check_val("rst_wena", wena, 0);
        check_val("rst_cpu_ack", cpu_ack, 0);
        check_val("rst_dma_ack", dma_ack, 0);
        check_val("rst_stall", cpu_stall, 1);
        check_val("rst_ram_addr", ram_addr, 0);
        check_val("rst_cpu_rdata", cpu_rdata, 0);
        rst = 1'b1;
        step();
        check_val("post_rst_rena", rena, 1);
        check_val("post_rst_addr", ram_addr, 32'h44);
        check_val("post_rst_stall", cpu_stall, 1);
        ram_rdata = 32'hA5A5_0001;
        step(); step();
        check_val("post_rst_rena3", rena, 1);
        step();
        check_val("post_rst_ack", cpu_ack, 1);
        check_val("post_rst_rdata", cpu_rdata, 32'hA5A5_0001);
        check_val("post_rst_ack_stall", cpu_stall, 0);
        check_val("post_rst_resp_rena", rena, 0);
        step();
        cpu_req = 1'b0;
        check_val("post_rst_ack_gone", cpu_ack, 0);

        // CPU read on the MEM_LAT=1 instance
        cpu_req1 = 1'b1; cpu_addr1 = 32'h10; ram_rdata1 = 32'hDEAD_BEEF;
        #1;
        check_val("l1_stall_n", cpu_stall1, 1);
        step();
        check_val("l1_rena", rena1, 1);
        check_val("l1_wena", wena1, 0);
        check_val("l1_addr", ram_addr1, 32'h10);
        check_val("l1_stall_n1", cpu_stall1, 1);
        check_val("l1_ack_early", cpu_ack1, 0);
        step();
        check_val("l1_ack", cpu_ack1, 1);
        check_val("l1_rdata", cpu_rdata1, 32'hDEAD_BEEF);
        check_val("l1_stall_ack", cpu_stall1, 0);
        check_val("l1_rena_resp", rena1, 0);
        step();
        cpu_req1 = 1'b0;
        check_val("l1_ack_once", cpu_ack1, 0);

        // DMA write, MEM_LAT=3; payload changes after issue must be ignored
        step();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'h1234_5678;
        ram_rdata = 32'hFFFF_0000;
        step();
        dma_addr = 32'h99; dma_wdata = 32'h0;
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("dw_wena%0d", k), wena, 1);
            check_val($sformatf("dw_rena%0d", k), rena, 0);
            check_val($sformatf("dw_addr%0d", k), ram_addr, 32'h20);
            check_val($sformatf("dw_wdata%0d", k), ram_wdata, 32'h1234_5678);
            check_val($sformatf("dw_ack%0d", k), dma_ack, 0);
            step();
        end
        check_val("dw_ack", dma_ack, 1);
        check_val("dw_cpu_ack", cpu_ack, 0);
        check_val("dw_wena_resp", wena, 0);
        check_val("dw_rdata_kept", dma_rdata, 0);
        step();
        dma_req = 1'b0; dma_we = 1'b0;
        check_val("dw_ack_once", dma_ack, 0);

        // Both masters requesting continuously
        cpu_req = 1'b1; cpu_we = 1'b0; dma_req = 1'b1; dma_we = 1'b0;
        nack = 0; nbad = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (cpu_ack && dma_ack) nbad++;
            if (rena && wena) nbad++;
            if (cpu_ack || dma_ack) begin
                if (nack < 10) got_dma[nack] = dma_ack;
                nack++;
            end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        check_val("arb_ack_count", nack, 10);
        check_val("arb_exclusive", nbad, 0);
        for (int j = 0; j < 10; j++) begin
`ifdef DRAM_ARB_RR_EN
            exp_dma = (j % 2 == 1);
`else
            exp_dma = (j % 5 == 4);
`endif
            check_val($sformatf("arb_grant%0d_is_dma", j), got_dma[j], exp_dma);
        end

        // DMA request arriving during a CPU access
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30; ram_rdata = 32'h0BAD_F00D;
        step();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40;
        step(); step();
        check_val("late_cpu_addr", ram_addr, 32'h30);
        step();
        check_val("late_cpu_ack", cpu_ack, 1);
        check_val("late_cpu_rdata", cpu_rdata, 32'h0BAD_F00D);
        check_val("late_dma_noack", dma_ack, 0);
        check_val("late_resp_rena", rena, 0);
        step();
        cpu_req = 1'b0;
        check_val("late_idle_rena", rena, 0);
        step();
        check_val("late_dma_rena", rena, 1);
        check_val("late_dma_addr", ram_addr, 32'h40);
        ram_rdata = 32'h5555_AAAA;
        step(); step(); step();
        check_val("late_dma_ack", dma_ack, 1);
        check_val("late_dma_rdata", dma_rdata, 32'h5555_AAAA);
        check_val("late_cpu_rdata_kept", cpu_rdata, 32'h0BAD_F00D);
        step();
        dma_req = 1'b0;

        // Reset asserted in the second ACCESS cycle of a CPU write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h50; cpu_wdata = 32'hCAFE_0050;
        step();
        check_val("mid_wena1", wena, 1);
        step();
        check_val("mid_wena2", wena, 1);
        #3;
        rst = 1'b0;
        #1;
        check_val("mid_wena_drop", wena, 0);
        check_val("mid_rena_drop", rena, 0);
        check_val("mid_stall", cpu_stall, 1);
        nack = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (cpu_ack || dma_ack) nack++;
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (cpu_ack || dma_ack || rena || wena) nack++;
        end
        check_val("mid_no_ack", nack, 0);
        check_val("mid_cpu_rdata_clr", cpu_rdata, 0);
        cpu_req = 1'b1; cpu_addr = 32'h60; ram_rdata = 32'h0000_6060;
        step();
        check_val("mid_restart_rena", rena, 1);
        check_val("mid_restart_addr", ram_addr, 32'h60);
        step(); step(); step();
        check_val("mid_restart_ack", cpu_ack, 1);
        check_val("mid_restart_rdata", cpu_rdata, 32'h0000_6060);
        step();
        cpu_req = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
